// File: rtl/controller_loop_cfg_issuer.sv
// controller_loop_cfg_issuer
// Turns a stream of 32-bit loop instructions into loop-controller
// configuration beats. It mirrors the controller's per-group loop counters,
// fires the block start pulse, waits for the controller's done, and then
// closes the block with block_done.
//
// Ports:
//   clk, reset             clock and synchronous active-low reset
//   inst_v/inst_ready      instruction handshake; inst_data carries the word
//                          (opcode [31:28], group [27:26], trip [15:0])
//   cfg_loop_iter_v        one-cycle config beat carrying cfg_loop_iter,
//                          cfg_loop_iter_loop_id and cfg_loop_group_id
//   start / done           block start pulse and controller completion pulse
//   block_done             one-cycle block close pulse
//   busy                   high while a block is in flight
//   blocks_done            count of completed blocks (wraps)
//   err_overflow, err_zero_trip, err_illegal   sticky error flags
//   err_clear              clears the sticky error flags
module controller_loop_cfg_issuer #(
  parameter int unsigned LOOP_ID_W     = 5,
  parameter int unsigned GROUP_ID_W    = 2,
  parameter int unsigned LOOP_ITER_W   = 16,
  parameter int unsigned NUM_MAX_LOOPS = 1 << LOOP_ID_W,
  parameter int unsigned NUM_GROUPS    = 1 << GROUP_ID_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_v,
  output logic                   inst_ready,
  input  logic [31:0]            inst_data,
  output logic                   cfg_loop_iter_v,
  output logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  output logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
  output logic [GROUP_ID_W-1:0]  cfg_loop_group_id,
  output logic                   start,
  input  logic                   done,
  output logic                   block_done,
  output logic                   busy,
  output logic [15:0]            blocks_done,
  output logic                   err_overflow,
  output logic                   err_zero_trip,
  output logic                   err_illegal,
  input  logic                   err_clear
);

  // Counter is one bit wider than the loop id so "group full" is representable.
  localparam int unsigned CNT_W = LOOP_ID_W + 1;
  localparam logic [3:0] OP_LOOP_CFG    = 4'h1;
  localparam logic [3:0] OP_BLOCK_START = 4'h2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    CLOSE     = 2'd3
  } state_t;

  state_t state, state_nx;

  logic             done_pend, done_pend_nx;
  logic [CNT_W-1:0] cnt    [NUM_GROUPS];
  logic [CNT_W-1:0] cnt_nx [NUM_GROUPS];

  logic                   beat_v_nx;
  logic [LOOP_ITER_W-1:0] iter_nx;
  logic [LOOP_ID_W-1:0]   loop_id_nx;
  logic [GROUP_ID_W-1:0]  group_id_nx;
  logic                   start_nx;
  logic                   block_done_nx;
  logic                   busy_nx;
  logic [15:0]            blocks_done_nx;
  logic                   ovf_ev, zero_ev, ill_ev;
  logic                   err_overflow_nx, err_zero_trip_nx, err_illegal_nx;

  // Instruction field decode.
  logic [3:0]            opcode;
  logic [GROUP_ID_W-1:0] grp_in;
  logic [15:0]           trip;
  logic                  xfer;
  logic                  unused_bits;

  assign opcode      = inst_data[31:28];
  assign grp_in      = GROUP_ID_W'(inst_data[27:26]);
  assign trip        = inst_data[15:0];
  assign unused_bits = ^inst_data[25:16];

  // Ready only in IDLE and never while reset is held.
  assign inst_ready = (state == IDLE) && reset;
  assign xfer       = inst_v && inst_ready;

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_nx       = state;
    done_pend_nx   = done_pend;
    cnt_nx         = cnt;
    beat_v_nx      = 1'b0;
    iter_nx        = cfg_loop_iter;
    loop_id_nx     = cfg_loop_iter_loop_id;
    group_id_nx    = cfg_loop_group_id;
    start_nx       = 1'b0;
    block_done_nx  = 1'b0;
    blocks_done_nx = blocks_done;
    ovf_ev         = 1'b0;
    zero_ev        = 1'b0;
    ill_ev         = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          case (opcode)
            OP_LOOP_CFG: begin
              if (trip == 16'd0) zero_ev = 1'b1;
              if (cnt[grp_in] == CNT_W'(NUM_MAX_LOOPS)) begin
                ovf_ev = 1'b1;
              end else begin
                beat_v_nx   = 1'b1;
                loop_id_nx  = LOOP_ID_W'(cnt[grp_in]);
                group_id_nx = grp_in;
                // Trip 0 is issued as iteration 0 rather than wrapping.
                iter_nx     = (trip == 16'd0) ? '0 : LOOP_ITER_W'(trip - 16'd1);
                cnt_nx[grp_in] = cnt[grp_in] + CNT_W'(1);
              end
            end
            OP_BLOCK_START: begin
              state_nx = START;
              start_nx = 1'b1;
            end
            default: ill_ev = 1'b1;
          endcase
        end
      end
      START: begin
        state_nx = WAIT_DONE;
        // A done seen during START is remembered for the first WAIT_DONE cycle.
        if (done) done_pend_nx = 1'b1;
      end
      WAIT_DONE: begin
        if (done || done_pend) begin
          state_nx       = CLOSE;
          done_pend_nx   = 1'b0;
          block_done_nx  = 1'b1;
          blocks_done_nx = blocks_done + 16'd1;
        end
      end
      CLOSE: begin
        state_nx = IDLE;
        for (int i = 0; i < int'(NUM_GROUPS); i++) cnt_nx[i] = '0;
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);

    // A new error event beats a simultaneous clear.
    err_overflow_nx  = (err_overflow  && !err_clear) || ovf_ev;
    err_zero_trip_nx = (err_zero_trip && !err_clear) || zero_ev;
    err_illegal_nx   = (err_illegal   && !err_clear) || ill_ev;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= IDLE;
      done_pend             <= 1'b0;
      for (int i = 0; i < int'(NUM_GROUPS); i++) cnt[i] <= '0;
      cfg_loop_iter_v       <= 1'b0;
      cfg_loop_iter         <= '0;
      cfg_loop_iter_loop_id <= '0;
      cfg_loop_group_id     <= '0;
      start                 <= 1'b0;
      block_done            <= 1'b0;
      busy                  <= 1'b0;
      blocks_done           <= '0;
      err_overflow          <= 1'b0;
      err_zero_trip         <= 1'b0;
      err_illegal           <= 1'b0;
    end else begin
      state                 <= state_nx;
      done_pend             <= done_pend_nx;
      cnt                   <= cnt_nx;
      cfg_loop_iter_v       <= beat_v_nx;
      cfg_loop_iter         <= iter_nx;
      cfg_loop_iter_loop_id <= loop_id_nx;
      cfg_loop_group_id     <= group_id_nx;
      start                 <= start_nx;
      block_done            <= block_done_nx;
      busy                  <= busy_nx;
      blocks_done           <= blocks_done_nx;
      err_overflow          <= err_overflow_nx;
      err_zero_trip         <= err_zero_trip_nx;
      err_illegal           <= err_illegal_nx;
    end
  end

endmodule

// File: tb/tb_controller_loop_cfg_issuer.sv
// Bench for controller_loop_cfg_issuer: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the issuer.
module tb_controller_loop_cfg_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_v;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        cfg_loop_iter_v;
  logic [15:0] cfg_loop_iter;
  logic [4:0]  cfg_loop_iter_loop_id;
  logic [1:0]  cfg_loop_group_id;
  logic        start;
  logic        done;
  logic        block_done;
  logic        busy;
  logic [15:0] blocks_done;
  logic        err_overflow;
  logic        err_zero_trip;
  logic        err_illegal;
  logic        err_clear;

  controller_loop_cfg_issuer dut (
    .clk                  (clk),
    .reset                (reset),
    .inst_v               (inst_v),
    .inst_ready           (inst_ready),
    .inst_data            (inst_data),
    .cfg_loop_iter_v      (cfg_loop_iter_v),
    .cfg_loop_iter        (cfg_loop_iter),
    .cfg_loop_iter_loop_id(cfg_loop_iter_loop_id),
    .cfg_loop_group_id    (cfg_loop_group_id),
    .start                (start),
    .done                 (done),
    .block_done           (block_done),
    .busy                 (busy),
    .blocks_done          (blocks_done),
    .err_overflow         (err_overflow),
    .err_zero_trip        (err_zero_trip),
    .err_illegal          (err_illegal),
    .err_clear            (err_clear)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: phase 0 idle, 1 start, 2 waiting for done, 3 closing.
  int m_phase;
  bit m_pend;
  int m_cnt [4];
  bit m_v, m_start, m_bd;
  int m_id, m_iter, m_grp;
  int m_blocks;
  bit m_ovf, m_zt, m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input logic [31:0] d, input bit dn, input bit clr);
    bit ovf, zt, ill;
    int op, g, tr;
    ovf = 0; zt = 0; ill = 0;
    m_v = 0; m_start = 0; m_bd = 0;
    if (!r) begin
      m_phase = 0; m_pend = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_blocks = 0; m_ovf = 0; m_zt = 0; m_ill = 0;
      m_id = 0; m_iter = 0; m_grp = 0;
      return;
    end
    op = int'(d[31:28]); g = int'(d[27:26]); tr = int'(d[15:0]);
    if (m_phase == 0) begin
      if (v) begin
        if (op == 1) begin
          if (tr == 0) zt = 1;
          if (m_cnt[g] >= 32) ovf = 1;
          else begin
            m_v = 1; m_id = m_cnt[g]; m_grp = g;
            m_iter = (tr == 0) ? 0 : tr - 1;
            m_cnt[g]++;
          end
        end else if (op == 2) begin
          m_phase = 1; m_start = 1;
        end else ill = 1;
      end
    end else if (m_phase == 1) begin
      if (dn) m_pend = 1;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (dn || m_pend) begin
        m_phase = 3; m_pend = 0; m_bd = 1;
        m_blocks = (m_blocks + 1) % 65536;
      end
    end else begin
      m_phase = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end
    m_ovf = (m_ovf && !clr) || ovf;
    m_zt  = (m_zt  && !clr) || zt;
    m_ill = (m_ill && !clr) || ill;
  endtask

  task automatic compare();
    chk("inst_ready", 32'(inst_ready), 32'((m_phase == 0) && reset));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("cfg_v", 32'(cfg_loop_iter_v), 32'(m_v));
    if (m_v) begin
      chk("cfg_iter", 32'(cfg_loop_iter), 32'(m_iter));
      chk("cfg_id", 32'(cfg_loop_iter_loop_id), 32'(m_id));
      chk("cfg_grp", 32'(cfg_loop_group_id), 32'(m_grp));
    end
    chk("start", 32'(start), 32'(m_start));
    chk("block_done", 32'(block_done), 32'(m_bd));
    chk("blocks_done", 32'(blocks_done), 32'(m_blocks));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_zero_trip", 32'(err_zero_trip), 32'(m_zt));
    chk("err_illegal", 32'(err_illegal), 32'(m_ill));
  endtask

  // One clock: apply inputs, advance model at the edge, compare just after it.
  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit dn, input bit clr);
    reset = r; inst_v = v; inst_data = d; done = dn; err_clear = clr;
    @(posedge clk);
    model(r, v, d, dn, clr);
    #1;
    compare();
  endtask

  function automatic logic [31:0] cfg(input int g, input int tr);
    return {4'h1, 2'(g), 10'd0, 16'(tr)};
  endfunction

  localparam logic [31:0] BSTART = 32'h2000_0000;

  initial begin
    // Reset
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_ready", 32'(inst_ready), 0);
    chk("rst_blocks", 32'(blocks_done), 0);
    step(1, 0, 0, 0, 0);
    chk("ready_after_rst", 32'(inst_ready), 1);

    // Back-to-back LOOP_CFG to group 0
    step(1, 1, cfg(0, 4), 0, 0);
    chk("b0_id", 32'(cfg_loop_iter_loop_id), 0); chk("b0_iter", 32'(cfg_loop_iter), 3);
    step(1, 1, cfg(0, 8), 0, 0);
    chk("b1_id", 32'(cfg_loop_iter_loop_id), 1); chk("b1_iter", 32'(cfg_loop_iter), 7);
    step(1, 1, cfg(0, 3), 0, 0);
    chk("b2_id", 32'(cfg_loop_iter_loop_id), 2); chk("b2_iter", 32'(cfg_loop_iter), 2);
    chk("b2_ready", 32'(inst_ready), 1);
    step(1, 0, 0, 0, 0);
    chk("b_end_v", 32'(cfg_loop_iter_v), 0);

    // Independent group counters
    step(1, 1, cfg(2, 5), 0, 0);
    chk("g2_grp", 32'(cfg_loop_group_id), 2); chk("g2_id", 32'(cfg_loop_iter_loop_id), 0);
    chk("g2_iter", 32'(cfg_loop_iter), 4);
    step(1, 1, cfg(1, 2), 0, 0);
    chk("g1_grp", 32'(cfg_loop_group_id), 1); chk("g1_id", 32'(cfg_loop_iter_loop_id), 0);
    chk("g1_iter", 32'(cfg_loop_iter), 1);

    // Block with done 6 cycles after start
    step(1, 1, BSTART, 0, 0);
    chk("blk_start", 32'(start), 1); chk("blk_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    chk("blk_nostart", 32'(start), 0);
    step(1, 0, 0, 1, 0);
    chk("blk_bd", 32'(block_done), 1); chk("blk_cnt", 32'(blocks_done), 1);
    step(1, 0, 0, 0, 0);
    chk("blk_bd_off", 32'(block_done), 0);
    step(1, 0, 0, 0, 0);
    chk("blk_idle", 32'(busy), 0);
    step(1, 1, cfg(0, 2), 0, 0);
    chk("blk_reuse_id", 32'(cfg_loop_iter_loop_id), 0);

    // done during START
    step(1, 1, BSTART, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("early_no_bd", 32'(block_done), 0);
    step(1, 0, 0, 0, 0);
    chk("early_bd", 32'(block_done), 1); chk("early_cnt", 32'(blocks_done), 2);
    step(1, 0, 0, 0, 0);

    // Overflow of group 3
    for (int i = 0; i < 33; i++) begin
      step(1, 1, cfg(3, i + 1), 0, 0);
      if (i < 32) chk("ovf_id", 32'(cfg_loop_iter_loop_id), 32'(i));
    end
    chk("ovf_nobeat", 32'(cfg_loop_iter_v), 0);
    chk("ovf_flag", 32'(err_overflow), 1);
    step(1, 0, 0, 0, 1);
    chk("ovf_clr", 32'(err_overflow), 0);

    // Zero trip, illegal opcode, clear racing a new error
    step(1, 1, cfg(1, 0), 0, 0);
    chk("zt_v", 32'(cfg_loop_iter_v), 1); chk("zt_iter", 32'(cfg_loop_iter), 0);
    chk("zt_flag", 32'(err_zero_trip), 1);
    step(1, 1, 32'h7000_0005, 0, 0);
    chk("ill_nobeat", 32'(cfg_loop_iter_v), 0); chk("ill_flag", 32'(err_illegal), 1);
    step(1, 1, 32'h7000_0005, 0, 1);
    chk("race_ill", 32'(err_illegal), 1); chk("race_zt", 32'(err_zero_trip), 0);

    // Reset during WAIT_DONE
    step(1, 1, BSTART, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("abort_busy", 32'(busy), 0); chk("abort_bd", 32'(block_done), 0);
    chk("abort_cnt", 32'(blocks_done), 0); chk("abort_ill", 32'(err_illegal), 0);
    chk("abort_ready", 32'(inst_ready), 0);
    step(1, 0, 0, 1, 0);
    chk("abort_bd2", 32'(block_done), 0); chk("abort_ready2", 32'(inst_ready), 1);
    step(1, 1, cfg(2, 9), 0, 0);
    chk("abort_id", 32'(cfg_loop_iter_loop_id), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit r, v, dn, clr;
      int sel, op, tr;
      logic [31:0] d;
      r   = ($urandom_range(0, 199) != 0);
      v   = ($urandom_range(0, 1) == 1);
      dn  = ($urandom_range(0, 4) == 0);
      clr = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 99);
      if (sel < 65) op = 1;
      else if (sel < 75) op = 2;
      else begin
        op = $urandom_range(0, 15);
        if (op == 1 || op == 2) op = 9;
      end
      tr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 65535);
      d = {4'(op), 2'($urandom_range(0, 3)), 10'($urandom), 16'(tr)};
      step(r, v, d, dn, clr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_loop_cfg_issuer.md
Name: controller_loop_cfg_issuer

Overview:
Transmit side of the loop-configuration interface consumed by the loop-controller FSM group. It accepts a stream of 32-bit loop instructions and converts trip counts into the controller's cfg_loop_iter_v / cfg_loop_iter / loop_id / group_id beats. It mirrors the controller's per-group loop counters, fires the start pulse, waits for the controller's done, and then returns block_done to close the block. It sits between the instruction fetch buffer and the loop controller.

Parameters:
LOOP_ID_W, 5, loop index width.
GROUP_ID_W, 2, group index width.
LOOP_ITER_W, 16, iteration value width (must be <=16).
NUM_MAX_LOOPS, 1<<LOOP_ID_W, maximum loops per group.
NUM_GROUPS, 1<<GROUP_ID_W, number of groups.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset.
inst_v  in  1  instruction valid.
inst_ready  out  1  issuer can accept an instruction.
inst_data  in  32  instruction word.
cfg_loop_iter_v  out  1  one-cycle config beat.
cfg_loop_iter  out  LOOP_ITER_W  last iteration index (trip count - 1).
cfg_loop_iter_loop_id  out  LOOP_ID_W  loop slot being written.
cfg_loop_group_id  out  GROUP_ID_W  group being written.
start  out  1  one-cycle block start pulse.
done  in  1  controller completion pulse.
block_done  out  1  one-cycle block close pulse; controller clears its slots.
busy  out  1  high when the state is not IDLE.
blocks_done  out  16  count of completed blocks; wraps.
err_overflow  out  1  sticky: LOOP_CFG issued to a full group.
err_zero_trip  out  1  sticky: trip count of 0 received.
err_illegal  out  1  sticky: unknown opcode received.
err_clear  in  1  clears all sticky error flags.

Behaviour:
- Handshake: an instruction transfers when inst_v && inst_ready. inst_ready = (state==IDLE) && reset.
- Instruction format: opcode [31:28], group [27:26], trip count [15:0].
  - 4'h1 LOOP_CFG.
  - 4'h2 BLOCK_START; fields other than the opcode are ignored.
  - Any other opcode is dropped and sets err_illegal.
- LOOP_CFG, one-cycle latency:
  - The cycle after the transfer, cfg_loop_iter_v=1 with loop_id = cnt[group], group_id = group, and cfg_loop_iter = trip-1 truncated to LOOP_ITER_W.
  - cnt[group] then increments.
  - Trip count 0: emit 0 and set err_zero_trip.
  - If cnt[group]==NUM_MAX_LOOPS: no beat is issued and err_overflow is set. cnt is LOOP_ID_W+1 bits wide and never wraps.
  - Back-to-back LOOP_CFG at one per cycle is supported; state stays IDLE.
- States:
  - IDLE: a BLOCK_START transfer moves to START.
  - START: start=1 for exactly one cycle, then WAIT_DONE.
  - WAIT_DONE: when done (or done_pend) is seen, move to CLOSE.
  - CLOSE: block_done=1 for one cycle, all cnt[] cleared to 0, blocks_done += 1 (wrapping at 16 bits), then IDLE.
- done handling:
  - done is sampled in START and WAIT_DONE.
  - A done arriving in START is latched into done_pend and honoured on the first WAIT_DONE cycle, which then moves to CLOSE.
  - done in IDLE or CLOSE is ignored.
- BLOCK_START with all cnt[]==0 is legal: the controller's max_iter values are 0, so its done follows start.
- Outputs: all outputs are registered. cfg_loop_iter_v, start and block_done are single-cycle pulses and are never asserted together.
- Sticky errors: err_clear clears them. When err_clear and a new error event occur in the same cycle, the error wins (the flag stays set).
- Reset (reset==0, any state, mid-block included):
  - state becomes IDLE; done_pend and all cnt[] cleared.
  - All outputs 0, including blocks_done and the error flags.
  - inst_ready is held at 0 while reset is asserted.
  - No block_done is emitted for an aborted block.

Test Plan:
- LOOP_CFG to group 0 with trips 4, 8, 3 on consecutive cycles -> three consecutive beats with (loop_id, iter) = (0,3), (1,7), (2,2), all group 0; inst_ready stays 1.
- LOOP_CFG to group 2 with trip 5, then to group 1 with trip 2 -> beats (grp2, id0, iter 4) and (grp1, id0, iter 1); per-group counters are independent.
- BLOCK_START, then done 6 cycles after start -> start pulse on the cycle after acceptance, busy=1, block_done exactly one cycle after the done, blocks_done=1, and a following LOOP_CFG reuses loop_id 0.
- done asserted during the START cycle -> CLOSE is entered on the next cycle; no hang.
- 33 LOOP_CFGs to group 3 -> 32 beats (ids 0..31), err_overflow=1 after the 33rd; err_clear pulse -> 0.
- Trip count 0 -> iter 0 issued and err_zero_trip=1. Opcode 4'h7 -> no beat and err_illegal=1. reset=0 during WAIT_DONE -> IDLE, block_done never pulses, counters and flags read 0.
